bcd_seq_converter: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It consumes the ALU result word and produces packed BCD digits plus a sign flag for the decimal display path. It sits directly upstream of the seven-segment display driver. It reuses the per-digit add-3 correction, applied to all digits in parallel each cycle.

---
 rtl/bcd_seq_converter.sv | 89 ++++++++
 tb/tb_bcd_seq_converter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble binary-to-BCD converter, one bit per clock.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : conversion request, accepted in IDLE or DONE
//   signed_mode, bin_in    : operand, sampled with an accepted start
//   bcd_out, neg_out       : registered packed BCD result (units in [3:0]) and sign
//   busy, done             : conversion running / one-cycle result-valid pulse
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0] scr_q, scr_d, corr, bcd_q, bcd_d;
  logic sign_q, sign_d, neg_q, neg_d;
  logic accept, last, neg_in;
  // DONE accepts a new request so conversions can run back-to-back.
  assign accept = start && state_q != CONV;
  assign last = state_q == CONV && cnt_q == CW'(WIDTH - 1);
  assign neg_in = signed_mode & bin_in[WIDTH-1];
  // Add-3 correction on every digit of the pre-shift scratch value.
  always_comb begin
    corr = scr_q;
    for (int i = 0; i < DIGITS; i++)
      corr[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mag_d = mag_q;
    scr_d = scr_q;
    sign_d = sign_q;
    bcd_d = bcd_q;
    neg_d = neg_q;
    if (accept) begin
      state_d = CONV;
      cnt_d = '0;
      scr_d = '0;
      sign_d = neg_in;
      mag_d = neg_in ? (~bin_in) + WIDTH'(1) : bin_in;
    end else if (state_q == CONV) begin
      {scr_d, mag_d} = {corr, mag_q} << 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        state_d = DONE;
        bcd_d = scr_d;
        neg_d = sign_q;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mag_q <= '0;
      scr_q <= '0;
      sign_q <= 1'b0;
      bcd_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mag_q <= mag_d;
      scr_q <= scr_d;
      sign_q <= sign_d;
      bcd_q <= bcd_d;
      neg_q <= neg_d;
    end
  end
  assign bcd_out = bcd_q;
  assign neg_out = neg_q;
  assign busy = state_q == CONV;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed self-checking bench for bcd_seq_converter.
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed_mode = 1'b0;
  logic [7:0] bin_in = '0;
  logic [11:0] bcd_out;
  logic neg_out, busy, done;
  int errors = 0;
  int checks = 0;
  int cyc, bcnt, stray;
  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .bin_in(bin_in), .bcd_out(bcd_out), .neg_out(neg_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Counts falling edges (and busy samples) until done is seen, bounded.
  task automatic wait_done(output int n, output int b);
    n = 0;
    b = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (busy) b++;
      if (done) break;
    end
  endtask
  task automatic run(input string tag, input logic [7:0] v, input logic sm,
                     input logic [11:0] exp_bcd, input logic exp_neg);
    int n, b;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    signed_mode = sm;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = '0;
    signed_mode = 1'b0;
    wait_done(n, b);
    chk({tag, " latency"}, n, 9);
    chk({tag, " busy_cycles"}, b, 8);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " bcd"}, bcd_out, exp_bcd);
    chk({tag, " neg"}, neg_out, exp_neg);
    @(negedge clk);
    chk({tag, " done_pulse"}, {busy, done}, 2'b00);
  endtask
  initial begin
    #12;
    chk("reset outputs", {bcd_out, neg_out, busy, done}, 15'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", {bcd_out, neg_out, busy, done}, 15'h0);
    run("u_ff", 8'hFF, 1'b0, 12'h255, 1'b0);
    run("s_80", 8'h80, 1'b1, 12'h128, 1'b1);
    run("s_f9", 8'hF9, 1'b1, 12'h007, 1'b1);
    run("s_7f", 8'h7F, 1'b1, 12'h127, 1'b0);
    run("s_00", 8'h00, 1'b1, 12'h000, 1'b0);
    run("u_05", 8'h05, 1'b0, 12'h005, 1'b0);
    run("u_0a", 8'h0A, 1'b0, 12'h010, 1'b0);
    run("u_63", 8'h63, 1'b0, 12'h099, 1'b0);
    run("u_64", 8'h64, 1'b0, 12'h100, 1'b0);
    run("u_80", 8'h80, 1'b0, 12'h128, 1'b0);
    // start during CONV must be ignored
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd42;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = '0;
    wait_done(cyc, bcnt);
    chk("ignore latency", cyc, 7);
    chk("ignore bcd", bcd_out, 12'h042);
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) stray++;
    end
    chk("ignore no second conv", stray, 0);
    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'd17;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    chk("b2b first latency", cyc, 9);
    chk("b2b first busy", bcnt, 8);
    chk("b2b first bcd", bcd_out, 12'h017);
    chk("b2b busy low in done", busy, 0);
    start = 1'b1;
    bin_in = 8'd250;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = '0;
    wait_done(cyc, bcnt);
    chk("b2b second latency", cyc, 9);
    chk("b2b second busy", bcnt, 8);
    chk("b2b second bcd", bcd_out, 12'h250);
    chk("b2b second neg", neg_out, 0);
    @(negedge clk);
    chk("b2b idle", {busy, done}, 2'b00);
    // asynchronous reset mid-conversion
    @(negedge clk);
    start = 1'b1;
    bin_in = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", {bcd_out, neg_out, busy, done}, 15'h0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("reset held quiet", stray, 0);
    rst_n = 1'b1;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    chk("no done after reset", stray, 0);
    chk("bcd still clear", bcd_out, 12'h000);
    run("post_reset_99", 8'd99, 1'b0, 12'h099, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
